branch_resolver: RTL and testbench

Execute-stage branch resolution unit, the consuming end of the fetch/decode branch predictor. The predictor always predicts taken for opcodes 3'b000 (BL) and 3'b001 (conditional/BRA) and hands down the fall-through PC (LBPC) and saved PSW (LBPSW). This block evaluates the real condition against the live PSW flags when the branch reaches execute. On a not-taken outcome it squashes wrong-path fetch/decode work, redirects fetch to LBPC through a valid/ready handshake, and restores PSW. It also keeps saturating branch and mispredict statistics for the debug/visualization software.

---
 rtl/branch_resolver.sv | 85 ++++++++
 tb/tb_branch_resolver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: resolves predicted-taken branches in execute, redirects fetch on a mispredict and keeps branch statistics
module branch_resolver #(
   parameter int SQUASH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exec_valid,
   input  logic [2:0]  exec_three_msb,
   input  logic [2:0]  exec_cond,
   input  logic [3:0]  psw_flags,
   input  logic [15:0] lbpc,
   input  logic [15:0] lbpsw,
   input  logic        redirect_ready,
   input  logic        stats_clr,
   output logic        redirect_valid,
   output logic [15:0] redirect_pc,
   output logic        flush_if,
   output logic        flush_id,
   output logic        psw_restore_valid,
   output logic [15:0] psw_restore,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;
   state_t state, state_nxt;
   logic [3:0] sq_cnt;
   logic [7:0] cond_tbl;
   logic       flag_v, flag_n, flag_z, flag_c;
   logic       resolve, taken, mispredict;
   assign {flag_v, flag_n, flag_z, flag_c} = psw_flags;
   assign cond_tbl = {1'b1, flag_n ^ flag_v, ~(flag_n ^ flag_v), flag_n, ~flag_c, flag_c, ~flag_z, flag_z};
   // only branches reaching execute in IDLE are real-path and get resolved
   always_comb begin
      resolve    = exec_valid && exec_three_msb[2:1] == 2'b00 && state == IDLE;
      taken      = exec_three_msb[0] ? cond_tbl[exec_cond] : 1'b1;
      mispredict = resolve && !taken;
   end
   // next-state and state-decoded outputs
   always_comb begin
      state_nxt      = state;
      redirect_valid = state == REDIRECT;
      flush_if       = state != IDLE;
      flush_id       = state != IDLE;
      busy           = state != IDLE;
      case (state)
         IDLE:     state_nxt = mispredict ? REDIRECT : IDLE;
         REDIRECT: state_nxt = redirect_ready ? SQUASH : REDIRECT;
         SQUASH:   state_nxt = sq_cnt == 4'd0 ? IDLE : SQUASH;
         default:  state_nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   // redirect target, PSW restore and squash countdown
   always_ff @(posedge clk) begin
      if (rst) begin
         sq_cnt            <= 4'd0;
         redirect_pc       <= 16'h0000;
         psw_restore       <= 16'h0000;
         psw_restore_valid <= 1'b0;
      end else begin
         psw_restore_valid <= mispredict;
         if (mispredict) begin
            redirect_pc <= lbpc;
            psw_restore <= lbpsw;
         end
         if (state == REDIRECT && redirect_ready) sq_cnt <= 4'(SQUASH_CYCLES - 1);
         else if (state == SQUASH && sq_cnt != 4'd0) sq_cnt <= sq_cnt - 4'd1;
      end
   end
   // saturating statistics; a clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         branch_count     <= 16'h0000;
         mispredict_count <= 16'h0000;
      end else begin
         if (resolve && branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
         if (mispredict && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed checks of branch resolution, redirect handshake, squash timing and statistics
module tb_branch_resolver;
   logic        clk = 1'b0;
   logic        rst, exec_valid, redirect_ready, stats_clr;
   logic [2:0]  exec_three_msb, exec_cond;
   logic [3:0]  psw_flags;
   logic [15:0] lbpc, lbpsw;
   logic        redirect_valid, flush_if, flush_id, psw_restore_valid, busy;
   logic [15:0] redirect_pc, psw_restore, branch_count, mispredict_count;
   int checks = 0, failures = 0;
   logic [15:0] exp_br = 16'd0, exp_mp = 16'd0;
   logic [2:0]  tbl_cond  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
   logic [3:0]  tbl_flags [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b1100, 4'b1000, 4'b0000};
   logic        tbl_taken [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   branch_resolver #(.SQUASH_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .exec_valid(exec_valid), .exec_three_msb(exec_three_msb),
      .exec_cond(exec_cond), .psw_flags(psw_flags), .lbpc(lbpc), .lbpsw(lbpsw),
      .redirect_ready(redirect_ready), .stats_clr(stats_clr), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
      .psw_restore_valid(psw_restore_valid), .psw_restore(psw_restore),
      .branch_count(branch_count), .mispredict_count(mispredict_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic br(input logic [2:0] op, input logic [2:0] c, input logic [3:0] f);
      exec_valid = 1'b1;
      exec_three_msb = op;
      exec_cond = c;
      psw_flags = f;
      step();
      exec_valid = 1'b0;
   endtask

   task automatic recover();
      redirect_ready = 1'b1;
      step();
      step();
      step();
   endtask

   initial begin
      rst = 1'b1; exec_valid = 1'b0; redirect_ready = 1'b0; stats_clr = 1'b0;
      exec_three_msb = 3'b000; exec_cond = 3'b000; psw_flags = 4'b0000;
      lbpc = 16'h0000; lbpsw = 16'h0000;
      step(); step();
      rst = 1'b0;
      chk("rst_rv", 16'(redirect_valid), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_flush", 16'({flush_if, flush_id, psw_restore_valid}), 16'd0);
      chk("rst_bc", branch_count, 16'h0000);
      chk("rst_mc", mispredict_count, 16'h0000);
      chk("rst_pc", redirect_pc, 16'h0000);

      br(3'b001, 3'b000, 4'b0010);
      chk("beq_bc", branch_count, 16'd1);
      chk("beq_mc", mispredict_count, 16'd0);
      chk("beq_busy", 16'(busy), 16'd0);
      chk("beq_flush", 16'({flush_if, flush_id, redirect_valid}), 16'd0);

      lbpc = 16'h1004; lbpsw = 16'h00A5; redirect_ready = 1'b1;
      br(3'b001, 3'b001, 4'b0010);
      chk("bne_n1_rv", 16'(redirect_valid), 16'd1);
      chk("bne_n1_fl", 16'({flush_if, flush_id}), 16'b11);
      chk("bne_n1_prv", 16'(psw_restore_valid), 16'd1);
      chk("bne_pc", redirect_pc, 16'h1004);
      chk("bne_psw", psw_restore, 16'h00A5);
      chk("bne_mc", mispredict_count, 16'd1);
      chk("bne_bc", branch_count, 16'd2);
      step();
      chk("bne_n2_rv", 16'(redirect_valid), 16'd0);
      chk("bne_n2_fl", 16'({flush_if, flush_id}), 16'b11);
      chk("bne_n2_prv", 16'(psw_restore_valid), 16'd0);
      step();
      chk("bne_n3_fl", 16'({flush_if, flush_id, busy}), 16'b111);
      step();
      chk("bne_n4_idle", 16'({flush_if, flush_id, busy}), 16'b000);

      lbpc = 16'h2222; lbpsw = 16'h0011; redirect_ready = 1'b0;
      br(3'b001, 3'b101, 4'b0100);
      chk("bge_n1_rv", 16'(redirect_valid), 16'd1);
      lbpc = 16'h9999;
      for (int i = 0; i < 5; i++) begin
         exec_valid = 1'b1; exec_three_msb = 3'b001; exec_cond = 3'b111;
         step();
         chk("bge_hold_rv", 16'(redirect_valid), 16'd1);
         chk("bge_hold_pc", redirect_pc, 16'h2222);
      end
      chk("bge_prv_once", 16'(psw_restore_valid), 16'd0);
      exec_valid = 1'b0; redirect_ready = 1'b1;
      step();
      chk("bge_sq_rv", 16'(redirect_valid), 16'd0);
      chk("bge_sq_fl", 16'(flush_if), 16'd1);
      chk("bge_bc", branch_count, 16'd3);
      chk("bge_mc", mispredict_count, 16'd2);
      step(); step();
      chk("bge_idle", 16'(busy), 16'd0);

      exp_br = 16'd3; exp_mp = 16'd2;
      br(3'b000, 3'b000, 4'b0000);
      exp_br++;
      chk("bl_busy", 16'(busy), 16'd0);
      br(3'b001, 3'b111, 4'b0000);
      exp_br++;
      chk("bra_busy", 16'(busy), 16'd0);
      chk("bl_bra_mc", mispredict_count, exp_mp);
      chk("bl_bra_bc", branch_count, exp_br);
      br(3'b010, 3'b000, 4'b0000);
      chk("nonbr_bc", branch_count, exp_br);
      exec_three_msb = 3'b001; exec_cond = 3'b000; step();
      chk("novalid_bc", branch_count, exp_br);

      for (int i = 0; i < 8; i++) begin
         lbpc = 16'h4000 + 16'(i);
         br(3'b001, tbl_cond[i], tbl_flags[i]);
         exp_br++;
         if (!tbl_taken[i]) exp_mp++;
         chk($sformatf("cond%0d_busy", i), 16'(busy), 16'(!tbl_taken[i]));
         chk($sformatf("cond%0d_mc", i), mispredict_count, exp_mp);
         if (!tbl_taken[i]) begin
            chk($sformatf("cond%0d_pc", i), redirect_pc, 16'h4000 + 16'(i));
            recover();
         end
      end
      chk("tbl_bc", branch_count, exp_br);

      step();
      force dut.mispredict_count = 16'hFFFE;
      #1 release dut.mispredict_count;
      br(3'b001, 3'b000, 4'b0000);
      chk("sat_fffe", mispredict_count, 16'hFFFF);
      recover();
      br(3'b001, 3'b000, 4'b0000);
      chk("sat_hold", mispredict_count, 16'hFFFF);
      recover();
      stats_clr = 1'b1;
      br(3'b001, 3'b000, 4'b0000);
      stats_clr = 1'b0;
      chk("clr_mc", mispredict_count, 16'h0000);
      chk("clr_bc", branch_count, 16'h0000);
      chk("clr_rv", 16'(redirect_valid), 16'd1);
      recover();

      br(3'b001, 3'b000, 4'b0000);
      step(); step();
      chk("rst_mid_sq", 16'(busy), 16'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_rv", 16'(redirect_valid), 16'd0);
      chk("abort_fl", 16'({flush_if, flush_id, psw_restore_valid, busy}), 16'd0);
      chk("abort_pc", redirect_pc, 16'h0000);
      chk("abort_mc", mispredict_count, 16'h0000);
      lbpc = 16'h3030; lbpsw = 16'h0077;
      br(3'b001, 3'b110, 4'b0000);
      chk("blt_rv", 16'(redirect_valid), 16'd1);
      chk("blt_pc", redirect_pc, 16'h3030);
      chk("blt_psw", psw_restore, 16'h0077);
      chk("blt_mc", mispredict_count, 16'd1);
      recover();
      chk("blt_idle", 16'(busy), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
